// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the clock-divider bank: select width,
// reset defaults and the configuration clamp rules.
package clk_div_pkg;

  // Widest ratio/high-time field the clamp helpers can handle
  localparam int MAX_W = 64;

  // Ratio a channel runs at straight out of reset when not overridden
  localparam int DEFAULT_RST_RATIO = 2;

  // Channel select width, at least one bit even for a single channel
  function automatic int sel_width(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // High-time paired with a reset ratio
  function automatic int rst_high_time(input int ratio);
    return ratio / 2;
  endfunction

  // Ratios below 2 cannot produce both a high and a low phase
  function automatic logic [MAX_W-1:0] clamp_ratio(input logic [MAX_W-1:0] n);
    return (n < MAX_W'(2)) ? MAX_W'(2) : n;
  endfunction

  // High-time must leave at least one high and one low cycle per period
  function automatic logic [MAX_W-1:0] clamp_high(input logic [MAX_W-1:0] n,
                                                  input logic [MAX_W-1:0] h);
    logic [MAX_W-1:0] n_c;
    n_c = clamp_ratio(n);
    if (h == '0) return MAX_W'(1);
    if (h >= n_c) return n_c - MAX_W'(1);
    return h;
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: free-running counter with an active ratio/high-time
// pair and a shadow pair that only takes over at a period boundary.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int RST_RATIO = DEFAULT_RST_RATIO
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic             sync,
  input  logic [WIDTH-1:0] ratio_in,
  input  logic [WIDTH-1:0] high_in,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] RST_N = WIDTH'(RST_RATIO);
  localparam logic [WIDTH-1:0] RST_H = WIDTH'(rst_high_time(RST_RATIO));
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] ratio_act;
  logic [WIDTH-1:0] high_act;
  logic [WIDTH-1:0] ratio_shd;
  logic [WIDTH-1:0] high_shd;
  logic [WIDTH-1:0] wr_ratio;
  logic [WIDTH-1:0] wr_high;
  logic [WIDTH-1:0] load_ratio;
  logic [WIDTH-1:0] load_high;
  logic             boundary;

  // Clamp incoming config, pick the config that survives a load, detect boundaries
  always_comb begin
    wr_ratio   = WIDTH'(clamp_ratio(MAX_W'(ratio_in)));
    wr_high    = WIDTH'(clamp_high(MAX_W'(ratio_in), MAX_W'(high_in)));
    load_ratio = pending ? ratio_shd : ratio_act;
    load_high  = pending ? high_shd : high_act;
    boundary   = (count == ratio_act - ONE) || sync;
  end

  // Counter, outputs and shadow handover; a same-edge write lands after any load
  always_ff @(posedge in_clk) begin
    if (!reset) begin
      count     <= RST_N - ONE;
      ratio_act <= RST_N;
      high_act  <= RST_H;
      ratio_shd <= RST_N;
      high_shd  <= RST_H;
      pending   <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      if (!en) begin
        count     <= load_ratio - ONE;
        ratio_act <= load_ratio;
        high_act  <= load_high;
        pending   <= 1'b0;
        clk_out   <= 1'b0;
        tick      <= 1'b0;
      end else if (boundary) begin
        count     <= '0;
        ratio_act <= load_ratio;
        high_act  <= load_high;
        pending   <= 1'b0;
        clk_out   <= 1'b1;
        tick      <= 1'b1;
      end else begin
        count   <= count + ONE;
        clk_out <= (count + ONE) < high_act;
        tick    <= 1'b0;
      end
      if (wr) begin
        ratio_shd <= wr_ratio;
        high_shd  <= wr_high;
        pending   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock dividers sharing one clock; the top only routes
// the write strobe to the selected channel and broadcasts sync.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int  NCH       = 4,
  parameter int  WIDTH     = 32,
  parameter int  RST_RATIO = DEFAULT_RST_RATIO,
  localparam int SEL_W     = sel_width(NCH)
) (
  input  logic             in_clk,
  input  logic             reset,
  input  logic [NCH-1:0]   en,
  input  logic             wr,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic [WIDTH-1:0] ratio_in,
  input  logic [WIDTH-1:0] high_in,
  input  logic             sync,
  output logic [NCH-1:0]   clk_out,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   pending
);

  logic [NCH-1:0] wr_ch;

  // Decode the write strobe; selects beyond the last channel match nothing
  always_comb begin
    wr_ch = '0;
    for (int i = 0; i < NCH; i++) begin
      wr_ch[i] = wr && (int'(ch_sel) == i);
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    clk_div_channel #(
      .WIDTH    (WIDTH),
      .RST_RATIO(RST_RATIO)
    ) u_ch (
      .in_clk  (in_clk),
      .reset   (reset),
      .en      (en[g]),
      .wr      (wr_ch[g]),
      .sync    (sync),
      .ratio_in(ratio_in),
      .high_in (high_in),
      .clk_out (clk_out[g]),
      .tick    (tick[g]),
      .pending (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed scenarios followed by a
// random phase, every cycle compared against a period-position model.
module tb_clk_div_bank;

  localparam int NCH       = 4;
  localparam int WIDTH     = 32;
  localparam int RST_RATIO = 4;

  logic             in_clk = 1'b0;
  logic             reset;
  logic [NCH-1:0]   en;
  logic             wr;
  logic [1:0]       ch_sel;
  logic [WIDTH-1:0] ratio_in;
  logic [WIDTH-1:0] high_in;
  logic             sync;
  logic [NCH-1:0]   clk_out;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   pending;

  int checks_total  = 0;
  int checks_passed = 0;
  int checks_failed = 0;

  // Model: active (n,h), shadow (sn,sh), position inside the current period
  longint   m_n[NCH];
  longint   m_h[NCH];
  longint   m_sn[NCH];
  longint   m_sh[NCH];
  longint   m_pos[NCH];
  bit       m_pend[NCH];
  bit       m_armed[NCH];
  logic [NCH-1:0] exp_clk;
  logic [NCH-1:0] exp_tick;
  logic [NCH-1:0] exp_pend;

  logic [31:0] pat_a;
  logic [31:0] pat_b;

  clk_div_bank #(
    .NCH      (NCH),
    .WIDTH    (WIDTH),
    .RST_RATIO(RST_RATIO)
  ) dut (
    .in_clk  (in_clk),
    .reset   (reset),
    .en      (en),
    .wr      (wr),
    .ch_sel  (ch_sel),
    .ratio_in(ratio_in),
    .high_in (high_in),
    .sync    (sync),
    .clk_out (clk_out),
    .tick    (tick),
    .pending (pending)
  );

  always #5 in_clk = ~in_clk;

  function automatic longint clamp_n(input longint n);
    return (n < 2) ? 2 : n;
  endfunction

  function automatic longint clamp_h(input longint n, input longint h);
    longint nc;
    nc = clamp_n(n);
    if (h == 0) return 1;
    if (h >= nc) return nc - 1;
    return h;
  endfunction

  // Advance the model by one clock edge using the inputs the DUT sampled
  task automatic model_edge();
    for (int c = 0; c < NCH; c++) begin
      if (!reset) begin
        m_n[c]   = RST_RATIO;
        m_h[c]   = RST_RATIO / 2;
        m_sn[c]  = RST_RATIO;
        m_sh[c]  = RST_RATIO / 2;
        m_pend[c]  = 1'b0;
        m_armed[c] = 1'b1;
        m_pos[c]   = 0;
        exp_clk[c]  = 1'b0;
        exp_tick[c] = 1'b0;
      end else begin
        if (!en[c]) begin
          if (m_pend[c]) begin
            m_n[c] = m_sn[c];
            m_h[c] = m_sh[c];
            m_pend[c] = 1'b0;
          end
          m_armed[c]  = 1'b1;
          exp_clk[c]  = 1'b0;
          exp_tick[c] = 1'b0;
        end else if (m_armed[c] || sync || m_pos[c] == m_n[c] - 1) begin
          if (m_pend[c]) begin
            m_n[c] = m_sn[c];
            m_h[c] = m_sh[c];
            m_pend[c] = 1'b0;
          end
          m_armed[c]  = 1'b0;
          m_pos[c]    = 0;
          exp_clk[c]  = 1'b1;
          exp_tick[c] = 1'b1;
        end else begin
          m_pos[c]    = m_pos[c] + 1;
          exp_clk[c]  = (m_pos[c] < m_h[c]);
          exp_tick[c] = 1'b0;
        end
        if (wr && int'(ch_sel) == c) begin
          m_sn[c]   = clamp_n(longint'(ratio_in));
          m_sh[c]   = clamp_h(longint'(ratio_in), longint'(high_in));
          m_pend[c] = 1'b1;
        end
      end
      exp_pend[c] = m_pend[c];
    end
  endtask

  task automatic check_output(input string tag, input int ch,
                              input logic observed, input logic expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s ch%0d: observed %0b expected %0b", tag, ch, observed, expected);
    end
  endtask

  task automatic check_vec(input string tag, input logic [31:0] observed,
                           input logic [31:0] expected);
    checks_total++;
    assert (observed === expected) checks_passed++;
    else begin
      checks_failed++;
      $error("[TB] FAIL %s: observed %0b expected %0b", tag, observed, expected);
    end
  endtask

  // One clock edge: update the model at the edge, compare just after it
  task automatic apply_stimulus();
    @(posedge in_clk);
    model_edge();
    #1;
    for (int c = 0; c < NCH; c++) begin
      check_output("clk_out", c, clk_out[c], exp_clk[c]);
      check_output("tick", c, tick[c], exp_tick[c]);
      check_output("pending", c, pending[c], exp_pend[c]);
    end
  endtask

  task automatic write_cfg(input int ch, input int n, input int h);
    ch_sel   = 2'(ch);
    ratio_in = WIDTH'(n);
    high_in  = WIDTH'(h);
    wr       = 1'b1;
    apply_stimulus();
    wr       = 1'b0;
  endtask

  // Step until the next edge is a natural wrap of channel ch (bounded)
  task automatic wait_boundary(input int ch);
    for (int k = 0; k < 64; k++) begin
      if (!m_armed[ch] && m_pos[ch] == m_n[ch] - 1) return;
      apply_stimulus();
    end
    checks_total++;
    checks_failed++;
    $error("[TB] FAIL wait_boundary ch%0d: observed no wrap expected one within 64 cycles", ch);
  endtask

  initial begin
    reset    = 1'b0;
    en       = '0;
    wr       = 1'b0;
    ch_sel   = '0;
    ratio_in = '0;
    high_in  = '0;
    sync     = 1'b0;

    $display("[TB] reset state");
    repeat (2) apply_stimulus();
    check_vec("reset outputs", {20'd0, clk_out, tick, pending}, 32'd0);
    reset = 1'b1;
    apply_stimulus();

    $display("[TB] ch0 N=5 H=2");
    write_cfg(0, 5, 2);
    en = 4'b0001;
    pat_a = '0;
    pat_b = '0;
    for (int k = 0; k < 10; k++) begin
      apply_stimulus();
      pat_a = {pat_a[30:0], clk_out[0]};
      pat_b = {pat_b[30:0], tick[0]};
    end
    check_vec("ch0 clk pattern", pat_a, 32'b1100011000);
    check_vec("ch0 tick pattern", pat_b, 32'b1000010000);

    $display("[TB] ch1 reconfig mid-period");
    write_cfg(1, 4, 2);
    en = 4'b0011;
    repeat (2) apply_stimulus();
    write_cfg(1, 6, 3);
    check_output("pending after wr", 1, pending[1], 1'b1);
    apply_stimulus();
    check_output("pending before boundary", 1, pending[1], 1'b1);
    pat_a = '0;
    for (int k = 0; k < 6; k++) begin
      apply_stimulus();
      pat_a = {pat_a[30:0], clk_out[1]};
    end
    check_vec("ch1 new period", pat_a, 32'b111000);
    check_output("pending after boundary", 1, pending[1], 1'b0);

    $display("[TB] clamping");
    write_cfg(2, 1, 0);
    write_cfg(3, 8, 9);
    en = 4'b1111;
    pat_a = '0;
    pat_b = '0;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus();
      pat_a = {pat_a[30:0], clk_out[2]};
      pat_b = {pat_b[30:0], clk_out[3]};
    end
    check_vec("ch2 clamp N=2 H=1", pat_a, 32'b10101010);
    check_vec("ch3 clamp H=7", pat_b, 32'b11111110);

    $display("[TB] sync realign");
    write_cfg(1, 3, 1);
    write_cfg(3, 7, 3);
    repeat (9) apply_stimulus();
    sync = 1'b1;
    apply_stimulus();
    sync = 1'b0;
    check_vec("sync clk_out", {28'd0, clk_out}, 32'b1111);
    check_vec("sync tick", {28'd0, tick}, 32'b1111);
    repeat (3) apply_stimulus();

    $display("[TB] wr at boundary, sync at wrap");
    write_cfg(0, 7, 3);
    wait_boundary(0);
    write_cfg(0, 3, 1);
    check_output("boundary tick", 0, tick[0], 1'b1);
    check_output("pending after boundary wr", 0, pending[0], 1'b1);
    repeat (10) apply_stimulus();
    wait_boundary(1);
    sync = 1'b1;
    apply_stimulus();
    sync = 1'b0;
    check_output("sync+wrap tick", 1, tick[1], 1'b1);
    apply_stimulus();
    check_output("no double tick", 1, tick[1], 1'b0);

    $display("[TB] reset mid-period");
    repeat (2) apply_stimulus();
    reset = 1'b0;
    apply_stimulus();
    check_vec("reset mid-period", {20'd0, clk_out, tick, pending}, 32'd0);
    reset = 1'b1;
    pat_a = '0;
    for (int k = 0; k < 8; k++) begin
      apply_stimulus();
      pat_a = {pat_a[30:0], clk_out[0]};
    end
    check_vec("post-reset RST_RATIO timing", pat_a, 32'b11001100);

    $display("[TB] random phase");
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(19) == 0) en = 4'($urandom);
      wr       = ($urandom_range(5) == 0);
      ch_sel   = 2'($urandom);
      ratio_in = WIDTH'($urandom_range(9));
      high_in  = WIDTH'($urandom_range(10));
      sync     = ($urandom_range(24) == 0);
      reset    = ($urandom_range(99) != 0);
      apply_stimulus();
    end
    wr    = 1'b0;
    sync  = 1'b0;
    reset = 1'b1;
    apply_stimulus();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
